// File: rtl/regfile_bist_pkg.sv
// regfile_bist_pkg
// Shared types and helpers for the register file BIST collar.
//   - bank_e    : which register file a test address selects
//   - state_e   : collar sequencer states
//   - SEGS/SEG_W: default segment count/width of a vector register
//   - ta_*      : field extraction from the packed test address {bank, reg, seg}
//   - remap_idx : register index remap applied to both banks
// Configuration macro: REGFILE_BIST_ADDR_INVERT_EN
//   defined   -> index becomes {0, ~idx[W-2:0]} (PMBIST address ordering,
//                half the registers per bank are reachable)
//   undefined -> index used unmodified
package regfile_bist_pkg;

    typedef enum logic {
        BANK_INT = 1'b0,
        BANK_VEC = 1'b1
    } bank_e;

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_e;

    localparam int SEGS  = 8;
    localparam int SEG_W = 3;

    // Low-order mask of w ones
    function automatic logic [31:0] field_mask(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // Segment field sits in the least significant bits
    function automatic logic [31:0] ta_seg(input logic [31:0] a, input int seg_w);
        return a & field_mask(seg_w);
    endfunction

    // Register field sits directly above the segment field
    function automatic logic [31:0] ta_reg(input logic [31:0] a, input int seg_w, input int reg_w);
        return (a >> seg_w) & field_mask(reg_w);
    endfunction

    // Bank bit is the most significant bit of the test address
    function automatic bank_e ta_bank(input logic [31:0] a, input int seg_w, input int reg_w);
        return bank_e'(a[seg_w + reg_w]);
    endfunction

    // Register index as seen by the register file of width w
    function automatic logic [31:0] remap_idx(input logic [31:0] idx, input int w);
`ifdef REGFILE_BIST_ADDR_INVERT_EN
        return (~idx) & field_mask(w - 1);
`else
        return idx & field_mask(w);
`endif
    endfunction

endpackage

// File: rtl/regfile_bist_seg_mux.sv
// regfile_bist_seg_mux
// Combinational segment helper for the vector register file.
//   word    : full vector register read data
//   rd_seg  : segment returned on rd_data
//   wr_seg  : segment replaced by wr_data in merged
//   wr_data : new segment contents
//   rd_data : selected segment of word
//   merged  : word with segment wr_seg replaced
module regfile_bist_seg_mux
    import regfile_bist_pkg::*;
#(
    parameter int TEST_WIDTH = 32,
    parameter int NSEG       = SEGS,
    parameter int NSEG_W     = SEG_W
) (
    input  logic [TEST_WIDTH*NSEG-1:0] word,
    input  logic [NSEG_W-1:0]          rd_seg,
    input  logic [NSEG_W-1:0]          wr_seg,
    input  logic [TEST_WIDTH-1:0]      wr_data,
    output logic [TEST_WIDTH-1:0]      rd_data,
    output logic [TEST_WIDTH*NSEG-1:0] merged
);

    // Segment select for test reads
    always_comb begin
        rd_data = word[32'(rd_seg) * TEST_WIDTH +: TEST_WIDTH];
    end

    // Segment merge for the read-modify-write cycle
    always_comb begin
        merged = word;
        merged[32'(wr_seg) * TEST_WIDTH +: TEST_WIDTH] = wr_data;
    end

endmodule

// File: rtl/regfile_bist_collar.sv
// regfile_bist_collar
// MBIST collar between the core and the integer / vector register files.
// BIST=0: fully transparent, Q_T=0, BUSY_T=0.
// BIST=1: port B of both files masked; port A driven from the narrow test port.
//   Test reads register {bank,reg,seg} and return data one cycle later.
//   Integer writes go straight through on the accepting edge.
//   Vector writes take one extra RMW cycle that merges the segment into the
//   current register contents (BUSY_T high during that cycle).
// Ports:
//   clk, rst (sync, active high), BIST, CSN_T, WEN_T, A_T, D_T, Q_T, BUSY_T
//   *_i core-side inputs, *_o register-file-side outputs, rdata_a_i/vrdata_a_i
//   register file read data.
// Configuration macro: REGFILE_BIST_ADDR_INVERT_EN (index remap, see package).
module regfile_bist_collar
    import regfile_bist_pkg::*;
#(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int VADDR_WIDTH = 6,
    parameter int VDATA_WIDTH = 256,
    parameter int TEST_WIDTH  = 32,
    parameter int TA_WIDTH    = 1 + ((ADDR_WIDTH > VADDR_WIDTH) ? ADDR_WIDTH : VADDR_WIDTH)
                                  + $clog2(VDATA_WIDTH / TEST_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   BIST,
    input  logic                   CSN_T,
    input  logic                   WEN_T,
    input  logic [TA_WIDTH-1:0]    A_T,
    input  logic [TEST_WIDTH-1:0]  D_T,
    output logic [TEST_WIDTH-1:0]  Q_T,
    output logic                   BUSY_T,
    // integer register file, core side
    input  logic [ADDR_WIDTH-1:0]  raddr_a_i,
    input  logic [ADDR_WIDTH-1:0]  waddr_a_i,
    input  logic [DATA_WIDTH-1:0]  wdata_a_i,
    input  logic                   we_a_i,
    input  logic [ADDR_WIDTH-1:0]  waddr_b_i,
    input  logic [DATA_WIDTH-1:0]  wdata_b_i,
    input  logic                   we_b_i,
    // integer register file, RF side
    output logic [ADDR_WIDTH-1:0]  raddr_a_o,
    input  logic [DATA_WIDTH-1:0]  rdata_a_i,
    output logic [ADDR_WIDTH-1:0]  waddr_a_o,
    output logic [DATA_WIDTH-1:0]  wdata_a_o,
    output logic                   we_a_o,
    output logic [ADDR_WIDTH-1:0]  waddr_b_o,
    output logic [DATA_WIDTH-1:0]  wdata_b_o,
    output logic                   we_b_o,
    // vector register file, core side
    input  logic [VADDR_WIDTH-1:0] vraddr_a_i,
    input  logic [VADDR_WIDTH-1:0] vwaddr_a_i,
    input  logic [VDATA_WIDTH-1:0] vwdata_a_i,
    input  logic                   vwe_a_i,
    input  logic [VADDR_WIDTH-1:0] vwaddr_b_i,
    input  logic [VDATA_WIDTH-1:0] vwdata_b_i,
    input  logic                   vwe_b_i,
    // vector register file, RF side
    output logic [VADDR_WIDTH-1:0] vraddr_a_o,
    input  logic [VDATA_WIDTH-1:0] vrdata_a_i,
    output logic [VADDR_WIDTH-1:0] vwaddr_a_o,
    output logic [VDATA_WIDTH-1:0] vwdata_a_o,
    output logic                   vwe_a_o,
    output logic [VADDR_WIDTH-1:0] vwaddr_b_o,
    output logic [VDATA_WIDTH-1:0] vwdata_b_o,
    output logic                   vwe_b_o
);

    localparam int REG_W = (ADDR_WIDTH > VADDR_WIDTH) ? ADDR_WIDTH : VADDR_WIDTH;
    localparam int NSEG  = VDATA_WIDTH / TEST_WIDTH;
    localparam int SEGW  = $clog2(NSEG);

    state_e                   state_r, next_state_s;
    bank_e                    req_bank_s, rd_bank_r;
    logic [REG_W-1:0]         req_reg_s, rd_reg_r;
    logic [SEGW-1:0]          req_seg_s, rd_seg_r, rmw_seg_r;
    logic [VADDR_WIDTH-1:0]   rmw_addr_r;
    logic [TEST_WIDTH-1:0]    rmw_data_r, rd_seg_q_s;
    logic [VDATA_WIDTH-1:0]   merged_s;
    logic [ADDR_WIDTH-1:0]    req_int_idx_s, rd_int_idx_s;
    logic [VADDR_WIDTH-1:0]   req_vec_idx_s, rd_vec_idx_s;
    logic                     accept_s, rd_acc_s, int_wr_s, vec_wr_s, rmw_fire_s;

    assign req_bank_s    = ta_bank(32'(A_T), SEGW, REG_W);
    assign req_reg_s     = REG_W'(ta_reg(32'(A_T), SEGW, REG_W));
    assign req_seg_s     = SEGW'(ta_seg(32'(A_T), SEGW));
    assign req_int_idx_s = ADDR_WIDTH'(remap_idx(32'(req_reg_s), ADDR_WIDTH));
    assign req_vec_idx_s = VADDR_WIDTH'(remap_idx(32'(req_reg_s), VADDR_WIDTH));
    assign rd_int_idx_s  = ADDR_WIDTH'(remap_idx(32'(rd_reg_r), ADDR_WIDTH));
    assign rd_vec_idx_s  = VADDR_WIDTH'(remap_idx(32'(rd_reg_r), VADDR_WIDTH));

    // Requests arriving during RMW are dropped; reset blocks any RF write.
    assign accept_s   = BIST && !CSN_T && (state_r == IDLE) && !rst;
    assign rd_acc_s   = accept_s && WEN_T;
    assign int_wr_s   = accept_s && !WEN_T && (req_bank_s == BANK_INT);
    assign vec_wr_s   = accept_s && !WEN_T && (req_bank_s == BANK_VEC);
    // Dropping BIST or asserting reset during RMW aborts the write
    assign rmw_fire_s = BIST && (state_r == RMW) && !rst;

    regfile_bist_seg_mux #(
        .TEST_WIDTH (TEST_WIDTH),
        .NSEG       (NSEG),
        .NSEG_W     (SEGW)
    ) u_seg_mux (
        .word    (vrdata_a_i),
        .rd_seg  (rd_seg_r),
        .wr_seg  (rmw_seg_r),
        .wr_data (rmw_data_r),
        .rd_data (rd_seg_q_s),
        .merged  (merged_s)
    );

    // Next-state logic: a vector write enters RMW, RMW always returns to IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (vec_wr_s) begin
                    next_state_s = RMW;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RMW:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Read request register (rd_q): selects what Q_T shows
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_bank_r <= BANK_INT;
            rd_reg_r  <= {REG_W{1'b0}};
            rd_seg_r  <= {SEGW{1'b0}};
        end else if (rd_acc_s) begin
            rd_bank_r <= req_bank_s;
            rd_reg_r  <= req_reg_s;
            rd_seg_r  <= req_seg_s;
        end
    end

    // Vector write capture for the RMW cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            rmw_addr_r <= {VADDR_WIDTH{1'b0}};
            rmw_seg_r  <= {SEGW{1'b0}};
            rmw_data_r <= {TEST_WIDTH{1'b0}};
        end else if (vec_wr_s) begin
            rmw_addr_r <= req_vec_idx_s;
            rmw_seg_r  <= req_seg_s;
            rmw_data_r <= D_T;
        end
    end

    // RF-side port muxing: transparent by default, collar-driven under BIST
    always_comb begin
        raddr_a_o  = raddr_a_i;
        waddr_a_o  = waddr_a_i;
        wdata_a_o  = wdata_a_i;
        we_a_o     = we_a_i;
        waddr_b_o  = waddr_b_i;
        wdata_b_o  = wdata_b_i;
        we_b_o     = we_b_i;
        vraddr_a_o = vraddr_a_i;
        vwaddr_a_o = vwaddr_a_i;
        vwdata_a_o = vwdata_a_i;
        vwe_a_o    = vwe_a_i;
        vwaddr_b_o = vwaddr_b_i;
        vwdata_b_o = vwdata_b_i;
        vwe_b_o    = vwe_b_i;
        if (BIST) begin
            raddr_a_o  = rd_int_idx_s;
            waddr_a_o  = req_int_idx_s;
            wdata_a_o  = D_T;
            we_a_o     = int_wr_s;
            waddr_b_o  = {ADDR_WIDTH{1'b0}};
            wdata_b_o  = {DATA_WIDTH{1'b0}};
            we_b_o     = 1'b0;
            vraddr_a_o = (state_r == RMW) ? rmw_addr_r : rd_vec_idx_s;
            vwaddr_a_o = rmw_fire_s ? rmw_addr_r : {VADDR_WIDTH{1'b0}};
            vwdata_a_o = rmw_fire_s ? merged_s : {VDATA_WIDTH{1'b0}};
            vwe_a_o    = rmw_fire_s;
            vwaddr_b_o = {VADDR_WIDTH{1'b0}};
            vwdata_b_o = {VDATA_WIDTH{1'b0}};
            vwe_b_o    = 1'b0;
        end else begin
            vwe_b_o    = vwe_b_i;
        end
    end

    // Test read data: integer word or the selected vector segment
    always_comb begin
        if (!BIST) begin
            Q_T = {TEST_WIDTH{1'b0}};
        end else if (rd_bank_r == BANK_INT) begin
            Q_T = rdata_a_i;
        end else begin
            Q_T = rd_seg_q_s;
        end
    end

    assign BUSY_T = BIST && (state_r == RMW);

endmodule

// File: tb/tb_regfile_bist_collar.sv
module tb_regfile_bist_collar;

    logic         clk = 1'b0;
    logic         rst, BIST, CSN_T, WEN_T;
    logic [9:0]   A_T;
    logic [31:0]  D_T, Q_T;
    logic         BUSY_T;
    logic [4:0]   raddr_a_i, waddr_a_i, waddr_b_i, raddr_a_o, waddr_a_o, waddr_b_o;
    logic [31:0]  wdata_a_i, wdata_b_i, rdata_a_i, wdata_a_o, wdata_b_o;
    logic         we_a_i, we_b_i, we_a_o, we_b_o;
    logic [5:0]   vraddr_a_i, vwaddr_a_i, vwaddr_b_i, vraddr_a_o, vwaddr_a_o, vwaddr_b_o;
    logic [255:0] vwdata_a_i, vwdata_b_i, vrdata_a_i, vwdata_a_o, vwdata_b_o;
    logic         vwe_a_i, vwe_b_i, vwe_a_o, vwe_b_o;

    logic [31:0]  int_rf [32] = '{default: 32'd0};
    logic [255:0] vec_rf [64] = '{default: 256'd0};
    int           vwr_cnt = 0;
    int           n_chk = 0;
    int           n_fail = 0;

    typedef struct {
        logic        csn;
        logic        wen;
        logic        bank;
        logic [5:0]  rg;
        logic [2:0]  sg;
        logic [31:0] d;
        logic        chk_q;
        logic [31:0] exp_q;
        logic        exp_busy;
    } vec_t;

    vec_t tbl [16];

    regfile_bist_collar dut (
        .clk(clk), .rst(rst), .BIST(BIST), .CSN_T(CSN_T), .WEN_T(WEN_T),
        .A_T(A_T), .D_T(D_T), .Q_T(Q_T), .BUSY_T(BUSY_T),
        .raddr_a_i(raddr_a_i), .waddr_a_i(waddr_a_i), .wdata_a_i(wdata_a_i), .we_a_i(we_a_i),
        .waddr_b_i(waddr_b_i), .wdata_b_i(wdata_b_i), .we_b_i(we_b_i),
        .raddr_a_o(raddr_a_o), .rdata_a_i(rdata_a_i), .waddr_a_o(waddr_a_o),
        .wdata_a_o(wdata_a_o), .we_a_o(we_a_o), .waddr_b_o(waddr_b_o),
        .wdata_b_o(wdata_b_o), .we_b_o(we_b_o),
        .vraddr_a_i(vraddr_a_i), .vwaddr_a_i(vwaddr_a_i), .vwdata_a_i(vwdata_a_i),
        .vwe_a_i(vwe_a_i), .vwaddr_b_i(vwaddr_b_i), .vwdata_b_i(vwdata_b_i), .vwe_b_i(vwe_b_i),
        .vraddr_a_o(vraddr_a_o), .vrdata_a_i(vrdata_a_i), .vwaddr_a_o(vwaddr_a_o),
        .vwdata_a_o(vwdata_a_o), .vwe_a_o(vwe_a_o), .vwaddr_b_o(vwaddr_b_o),
        .vwdata_b_o(vwdata_b_o), .vwe_b_o(vwe_b_o)
    );

    always #5 clk = ~clk;

    // Behavioural register files; integer register 0 is hardwired to zero
    assign rdata_a_i  = (raddr_a_o == 5'd0) ? 32'd0 : int_rf[raddr_a_o];
    assign vrdata_a_i = vec_rf[vraddr_a_o];

    always @(posedge clk) begin
        if (we_a_o && waddr_a_o != 5'd0) int_rf[waddr_a_o] <= wdata_a_o;
        if (we_b_o && waddr_b_o != 5'd0) int_rf[waddr_b_o] <= wdata_b_o;
        if (vwe_a_o) vec_rf[vwaddr_a_o] <= vwdata_a_o;
        if (vwe_b_o) vec_rf[vwaddr_b_o] <= vwdata_b_o;
        if (vwe_a_o && BIST) vwr_cnt <= vwr_cnt + 1;
    end

    // Physical index the RF sees for a given test register number
    function automatic logic [4:0] phys_i(input logic [5:0] r);
`ifdef REGFILE_BIST_ADDR_INVERT_EN
        return {1'b0, ~r[3:0]};
`else
        return r[4:0];
`endif
    endfunction

    function automatic logic [5:0] phys_v(input logic [5:0] r);
`ifdef REGFILE_BIST_ADDR_INVERT_EN
        return {1'b0, ~r[4:0]};
`else
        return r;
`endif
    endfunction

    function automatic vec_t mk(input logic csn, input logic wen, input logic bank,
                                input logic [5:0] rg, input logic [2:0] sg, input logic [31:0] d,
                                input logic chk_q, input logic [31:0] exp_q, input logic exp_busy);
        vec_t v;
        v.csn = csn; v.wen = wen; v.bank = bank; v.rg = rg; v.sg = sg; v.d = d;
        v.chk_q = chk_q; v.exp_q = exp_q; v.exp_busy = exp_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int snap;
        // test-port sequence (BIST=1); one entry per cycle
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 6'd7, 3'd0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 6'd7, 3'd0, 32'h0,        1'b0, 32'h0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 6'd0, 3'd0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 6'd3, 3'd0, 32'h0,        1'b0, 32'h0, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b0, 6'd0, 3'd0, 32'h0,        1'b1, 32'h00001234, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 6'd2, 3'd3, 32'h0,        1'b0, 32'h0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 6'd2, 3'd5, 32'h12345678, 1'b0, 32'h0, 1'b1);
        tbl[7]  = mk(1'b0, 1'b1, 1'b1, 6'd2, 3'd0, 32'h0,        1'b0, 32'h0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b1, 6'd2, 3'd1, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 1'b1, 6'd2, 3'd2, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 1'b1, 6'd2, 3'd3, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 1'b1, 6'd2, 3'd4, 32'h0,        1'b1, 32'h00000000, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 1'b1, 6'd2, 3'd5, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 6'd2, 3'd6, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 1'b1, 6'd2, 3'd7, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0);
        tbl[15] = mk(1'b1, 1'b1, 1'b1, 6'd0, 3'd0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0);

        rst = 1'b1; BIST = 1'b1; CSN_T = 1'b1; WEN_T = 1'b1; A_T = 10'd0; D_T = 32'd0;
        raddr_a_i = 5'd0; waddr_a_i = 5'd0; wdata_a_i = 32'd0; we_a_i = 1'b0;
        waddr_b_i = 5'd0; wdata_b_i = 32'd0; we_b_i = 1'b0;
        vraddr_a_i = 6'd0; vwaddr_a_i = 6'd0; vwdata_a_i = 256'd0; vwe_a_i = 1'b0;
        vwaddr_b_i = 6'd0; vwdata_b_i = 256'd0; vwe_b_i = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_q", 256'(Q_T), 256'd0);
        check("reset_busy", 256'(BUSY_T), 256'd0);
        check("reset_vwe", 256'(vwe_a_o), 256'd0);

        // Transparent mode: core writes pass through untouched
        next_cycle();
        BIST = 1'b0; CSN_T = 1'b0; WEN_T = 1'b0; A_T = {1'b1, 6'd2, 3'd0}; D_T = 32'h0BADF00D;
        raddr_a_i = 5'd17; waddr_a_i = phys_i(6'd3); wdata_a_i = 32'h00001234; we_a_i = 1'b1;
        waddr_b_i = 5'd9; wdata_b_i = 32'h00000BAD; we_b_i = 1'b0;
        vraddr_a_i = 6'd11; vwaddr_a_i = phys_v(6'd2); vwdata_a_i = {256{1'b1}}; vwe_a_i = 1'b1;
        vwaddr_b_i = phys_v(6'd5); vwdata_b_i = {8{32'h5A5AC3C3}}; vwe_b_i = 1'b1;
        @(negedge clk);
        check("pt_raddr_a", 256'(raddr_a_o), 256'd17);
        check("pt_waddr_a", 256'(waddr_a_o), 256'(phys_i(6'd3)));
        check("pt_we_b", 256'(we_b_o), 256'd0);
        check("pt_wdata_b", 256'(wdata_b_o), 256'h0BAD);
        check("pt_vraddr_a", 256'(vraddr_a_o), 256'd11);
        check("pt_vwdata_b", vwdata_b_o, {8{32'h5A5AC3C3}});
        check("pt_q", 256'(Q_T), 256'd0);
        check("pt_busy", 256'(BUSY_T), 256'd0);
        next_cycle();
        we_a_i = 1'b0; vwe_a_i = 1'b0; vwe_b_i = 1'b0; CSN_T = 1'b1;
        @(negedge clk);
        check("pt_int_rf3", 256'(int_rf[phys_i(6'd3)]), 256'h1234);
        check("pt_vec_rf5", vec_rf[phys_v(6'd5)], {8{32'h5A5AC3C3}});
        check("pt_vec_rf2", vec_rf[phys_v(6'd2)], {256{1'b1}});
        check("pt_no_rmw", 256'(BUSY_T), 256'd0);

        // Test-port table with core port B trying to clobber the same registers
        next_cycle();
        BIST = 1'b1;
        waddr_b_i = phys_i(6'd7); wdata_b_i = 32'h00000055; we_b_i = 1'b1;
        vwaddr_b_i = phys_v(6'd2); vwdata_b_i = 256'd0; vwe_b_i = 1'b1;
        snap = vwr_cnt;
        for (int i = 0; i < 16; i++) begin
            CSN_T = tbl[i].csn; WEN_T = tbl[i].wen;
            A_T = {tbl[i].bank, tbl[i].rg, tbl[i].sg}; D_T = tbl[i].d;
            @(negedge clk);
            if (i == 0) begin
                check("mask_we_b", 256'(we_b_o), 256'd0);
                check("mask_vwe_b", 256'(vwe_b_o), 256'd0);
                check("mask_waddr_b", 256'(waddr_b_o), 256'd0);
                check("int_we_a", 256'(we_a_o), 256'd1);
            end
            if (tbl[i].chk_q) check($sformatf("tbl%0d_q", i), 256'(Q_T), 256'(tbl[i].exp_q));
            check($sformatf("tbl%0d_busy", i), 256'(BUSY_T), 256'(tbl[i].exp_busy));
            next_cycle();
        end
        CSN_T = 1'b1; we_b_i = 1'b0; vwe_b_i = 1'b0;
        @(negedge clk);
        check("rmw_write_count", 256'(vwr_cnt - snap), 256'd1);

        // BIST dropped during the RMW cycle: write aborted, core passes through
        next_cycle();
        snap = vwr_cnt;
        CSN_T = 1'b0; WEN_T = 1'b0; A_T = {1'b1, 6'd4, 3'd0}; D_T = 32'h0000CAFE;
        next_cycle();
        CSN_T = 1'b1; BIST = 1'b0; vraddr_a_i = 6'd9; vwaddr_a_i = 6'd13; vwe_a_i = 1'b0;
        @(negedge clk);
        check("drop_vwe", 256'(vwe_a_o), 256'd0);
        check("drop_vraddr", 256'(vraddr_a_o), 256'd9);
        check("drop_vwaddr", 256'(vwaddr_a_o), 256'd13);
        check("drop_busy", 256'(BUSY_T), 256'd0);
        next_cycle();
        BIST = 1'b1;
        @(negedge clk);
        check("drop_idle", 256'(BUSY_T), 256'd0);
        check("drop_vec_rf4", vec_rf[phys_v(6'd4)], 256'd0);
        check("drop_count", 256'(vwr_cnt - snap), 256'd0);

        // Reset during the RMW cycle: no write, back to idle
        next_cycle();
        CSN_T = 1'b0; WEN_T = 1'b0; A_T = {1'b1, 6'd6, 3'd1}; D_T = 32'h00000077;
        next_cycle();
        CSN_T = 1'b1; rst = 1'b1;
        @(negedge clk);
        check("rst_vwe", 256'(vwe_a_o), 256'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 256'(BUSY_T), 256'd0);
        check("rst_vec_rf6", vec_rf[phys_v(6'd6)], 256'd0);

        // Integer register 0: address decode and unwritable read-back
        next_cycle();
        CSN_T = 1'b0; WEN_T = 1'b0; A_T = {1'b0, 6'd0, 3'd5}; D_T = 32'h00000099;
        @(negedge clk);
        check("r0_we_a", 256'(we_a_o), 256'd1);
        check("r0_waddr", 256'(waddr_a_o), 256'(phys_i(6'd0)));
        check("r0_wdata", 256'(wdata_a_o), 256'h99);
        next_cycle();
        WEN_T = 1'b1;
        next_cycle();
        CSN_T = 1'b1;
        @(negedge clk);
`ifdef REGFILE_BIST_ADDR_INVERT_EN
        check("r0_read", 256'(Q_T), 256'h99);
`else
        check("r0_read", 256'(Q_T), 256'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
